seq_multiplier_32bit: RTL and testbench

//   Multi-cycle unsigned shift-and-add multiplier. It is the addition-based

---
 rtl/seq_multiplier_32bit_pkg.sv | 19 +
 rtl/mult_add_stage.sv | 32 +++
 rtl/seq_multiplier_32bit.sv | 101 ++++++++++
 tb/tb_seq_multiplier_32bit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_32bit_pkg.sv
// ----------------------------------------------------------------------------
// seq_multiplier_32bit_pkg: shared state encoding and default operand width
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seq_multiplier_32bit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_add_stage.sv
// ----------------------------------------------------------------------------
// mult_add_stage: WIDTH-bit ripple-carry adder (carry-in tied low) with carry-out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_add_stage
    import seq_multiplier_32bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b0;

    // One full-adder cell per bit, chained through w_carry
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/seq_multiplier_32bit.sv
// ----------------------------------------------------------------------------
// seq_multiplier_32bit: multi-cycle unsigned shift-and-add multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_multiplier_32bit
    import seq_multiplier_32bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [2*WIDTH-1:0]   p_q,       p_d;
    logic [CNT_W-1:0]     count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [2*WIDTH-1:0]   w_step;

    assign w_addend = p_q[0] ? mcand_q : '0;

    mult_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a    (p_q[2*WIDTH-1:WIDTH]),
        .i_b    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Carry lands in the top bit, so the full 2*WIDTH result stays exact
    assign w_step = {w_cout, w_sum, p_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mcand_d = multiplicand;
                    p_d     = {{WIDTH{1'b0}}, multiplier};
                    count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                p_d     = w_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    state_d   = ST_DONE;
                    product_d = w_step;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier_32bit.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier_32bit: self-checking bench for seq_multiplier_32bit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_multiplier_32bit;

    localparam int W       = 32;
    localparam int LATENCY = 32;   // negedges after the accept edge until done
    localparam int BOUND   = 48;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int errors = 0;
    int checks = 0;

    seq_multiplier_32bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Drive one accepted start; operand ports are scrambled afterwards
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Count negedges from the accept edge until done; -1 if the bound expires
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 0; k < BOUND; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #23;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta [4] = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678};
        logic [W-1:0]   tb [4] = '{32'd5, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0};
        logic [2*W-1:0] te [4] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFE_0000_0001, 64'd0, 64'd0};
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(lat, bok);
            checks++;
            if (lat != LATENCY || !bok) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d busy_ok=%0d expected %0d busy_ok=1", i, lat, bok, LATENCY);
            end
            checks++;
            if (product !== te[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_product: got %h busy=%b expected %h busy=0", i, product, busy, te[i]);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || product !== te[i]) begin
                errors++;
                $display("FAIL dir%0d_hold: done=%b busy=%b product=%h expected 0 0 %h", i, done, busy, product, te[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        start_op(32'd7, 32'd6);
        for (int k = 0; k < BOUND; k++) begin
            @(negedge clk);
            if (k == 8) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end else if (k == 9) begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != LATENCY || product !== 64'd42) begin
            errors++;
            $display("FAIL ignore_start: lat=%0d product=%h expected %0d %h", lat, product, LATENCY, 64'd42);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        start_op(32'd2, 32'd3);
        wait_done(lat, bok);
        checks++;
        if (lat != LATENCY || product !== 64'd6) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d product=%h expected %0d %h", lat, product, LATENCY, 64'd6);
        end
        start        = 1'b1;
        multiplicand = 32'd4;
        multiplier   = 32'd5;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rebusy: busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done(lat, bok);
        checks++;
        if (lat != LATENCY || !bok || product !== 64'd20) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d busy_ok=%0d product=%h expected %0d 1 %h", lat, bok, product, LATENCY, 64'd20);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse: done=%b expected 0", done);
        end
    endtask

    task automatic test_reset_mid_run();
        int bad = 0;
        start_op(32'd100, 32'd200);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || product !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stay_idle: %0d active cycles after reset, expected 0", bad);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_p;
        int lat;
        bit bok;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 6 == 1) a = 32'hFFFF_FFFF;
            if (i % 6 == 3) b = 32'h8000_0001;
            exp_p = model_mul(a, b);
            start_op(a, b);
            wait_done(lat, bok);
            checks++;
            if (lat != LATENCY || !bok || product !== exp_p) begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h lat=%0d busy_ok=%0d product=%h expected %0d 1 %h",
                         i, a, b, lat, bok, product, LATENCY, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
